// File: rtl/datapath_fsm.sv
// Instruction-register controller for a small register-file/ALU datapath.
// One instruction is decoded per start; every control output is a Moore function of state and IR.
module datapath_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WRITE  = 3'd5,
        S_WIMM   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        I_MOVI = 3'd0,
        I_MOVR = 3'd1,
        I_ADD  = 3'd2,
        I_CMP  = 3'd3,
        I_AND  = 3'd4,
        I_MVN  = 3'd5,
        I_ILL  = 3'd6
    } instr_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    instr_t      instr;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

    // Start handshake: s is the request, w the ready; a start is taken on an edge where both are 1.
    // The IR only listens while idle, so a busy instruction can never be corrupted.
    always_comb begin
        ir_d = ir_q;
        if (state_q == S_WAIT && load) begin
            ir_d = in;
        end
    end

    always_comb begin
        instr = I_ILL;
        if (opcode == 3'b110) begin
            if (op == 2'b10) begin
                instr = I_MOVI;
            end else if (op == 2'b00) begin
                instr = I_MOVR;
            end
        end else if (opcode == 3'b101) begin
            case (op)
                2'b00:   instr = I_ADD;
                2'b01:   instr = I_CMP;
                2'b10:   instr = I_AND;
                default: instr = I_MVN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (s) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (instr)
                    I_MOVI:               state_d = S_WIMM;
                    I_MOVR, I_MVN:        state_d = S_GET_B;
                    I_ADD, I_CMP, I_AND:  state_d = S_GET_A;
                    default:              state_d = S_WAIT;
                endcase
            end
            S_GET_A: state_d = S_GET_B;
            S_GET_B: state_d = S_EXEC;
            S_EXEC: begin
                if (instr == I_CMP) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_WAIT;
            S_WIMM:  state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        vsel     = 2'b00;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        ALUop    = 2'b00;
        shift    = 2'b00;
        illegal  = 1'b0;
        case (state_q)
            S_WAIT: begin
                w = 1'b1;
            end
            S_DECODE: begin
                illegal = (instr == I_ILL);
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = sh;
                loadc = (instr != I_CMP);
                loads = (instr != I_MOVR);
                // MOV-reg passes B through the adder with A forced to zero.
                if (instr == I_MOVR) begin
                    ALUop = 2'b00;
                    asel  = 1'b1;
                end else begin
                    ALUop = op;
                end
            end
            S_WRITE: begin
                writenum = rd;
                write    = 1'b1;
                vsel     = 2'b00;
            end
            S_WIMM: begin
                writenum = rn;
                write    = 1'b1;
                vsel     = 2'b01;
            end
            default: begin
                w = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_datapath_fsm.sv
// Bench for datapath_fsm: directed scenarios plus random instructions against a
// per-instruction cycle-list model, checked by a queue-based scoreboard.
module tb_datapath_fsm;

  logic        clk;
  logic        rst_n;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada, loadb, loadc, loads;
  logic        asel, bsel;
  logic [1:0]  ALUop;
  logic [1:0]  shift;
  logic [15:0] sximm8;
  logic        illegal;

  datapath_fsm dut (
    .clk(clk), .rst_n(rst_n), .s(s), .load(load), .in(in),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write),
    .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .ALUop(ALUop),
    .shift(shift), .sximm8(sximm8), .illegal(illegal)
  );

  localparam int W = 36;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_vec;
  int n_checks = 0;
  int n_pass   = 0;
  int idle_cnt = 0;

  assign act_vec = {illegal, readnum, writenum, write, vsel, loada, loadb,
                    loadc, loads, asel, bsel, ALUop, shift, sximm8};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] mk(input logic ill, input logic [2:0] rdn,
                                      input logic [2:0] wrn, input logic wr,
                                      input logic [1:0] vs, input logic la,
                                      input logic lb, input logic lc, input logic ls,
                                      input logic as, input logic [1:0] alu,
                                      input logic [1:0] shf, input logic [15:0] sx);
    return {ill, rdn, wrn, wr, vs, la, lb, lc, ls, as, 1'b0, alu, shf, sx};
  endfunction

  // Reference: list of expected non-idle cycles for one instruction.
  task automatic model_push(input logic [15:0] ir);
    logic [2:0]  opc, rn, rd, rm;
    logic [1:0]  op, sh;
    logic [15:0] sx;
    logic        movi, movr, alu, cmp, legal;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
    rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    sx = (ir[7:0] >= 8'd128) ? (16'(ir[7:0]) + 16'hFF00) : 16'(ir[7:0]);
    movi  = (opc == 3'd6) && (op == 2'd2);
    movr  = (opc == 3'd6) && (op == 2'd0);
    alu   = (opc == 3'd5);
    cmp   = alu && (op == 2'd1);
    legal = movi || movr || alu;
    exp_q.push_back(mk(!legal, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, sx));
    if (movi) begin
      exp_q.push_back(mk(0, 0, rn, 1, 2'd1, 0, 0, 0, 0, 0, 0, 0, sx));
    end else if (legal) begin
      if (alu && op != 2'd3)
        exp_q.push_back(mk(0, rn, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, sx));
      exp_q.push_back(mk(0, rm, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, sx));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, !cmp, alu, movr, alu ? op : 2'd0, sh, sx));
      if (!cmp)
        exp_q.push_back(mk(0, 0, rd, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0, sx));
    end
  endtask

  // monitor: idle cycles must be quiet; busy cycles pop the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (w) begin
        idle_cnt++;
        chk("idle_outputs", {act_vec[W-1:16], 16'h0}, '0);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_busy_cycle", act_vec, {W{1'bx}});
      end else begin
        chk("busy_cycle", act_vec, exp_q.pop_front());
      end
    end
  end

  // driver tasks (called #1 after a rising edge)
  task automatic wait_idle();
    int k;
    for (k = 0; k < 20 && w !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    if (w !== 1'b1) chk("wait_idle_timeout", {35'd0, w}, 36'd1);
  endtask

  task automatic issue(input logic [15:0] instr);
    in = instr; load = 1'b1; s = 1'b1;
    model_push(instr);
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0; in = 16'($urandom);
    wait_idle();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int idle0;
    rst_n = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", act_vec, '0);
    chk("reset_w", {35'd0, w}, 36'd1);
    tick(2);
    rst_n = 1'b1;

    issue(16'hA148);  // ADD R2,R1,R0,LSL#1
    issue(16'hA900);  // CMP R1,R0
    // MOV R0,#-5 with a spot check of the sign extension
    in = 16'hD0FB; load = 1'b1; s = 1'b1;
    model_push(16'hD0FB);
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    chk("movimm_sximm8", {20'd0, sximm8}, {20'd0, 16'hFFFB});
    wait_idle();
    issue(16'hE000);  // illegal
    tick(1);

    // load during EXEC must not disturb the IR
    in = 16'hA148; load = 1'b1; s = 1'b1;
    model_push(16'hA148);
    tick(1); load = 1'b0; s = 1'b0;
    tick(3); load = 1'b1; in = 16'hFFFF;
    tick(1); load = 1'b0; in = 16'h0000;
    chk("ir_hold_in_exec", {20'd0, sximm8}, {20'd0, 16'h0048});
    wait_idle();

    // s held high across two MOV-imm: exactly one idle cycle between them
    in = 16'hD305; load = 1'b1; s = 1'b1;
    model_push(16'hD305);
    tick(1); in = 16'hD480;
    tick(1);
    model_push(16'hD480);
    idle0 = idle_cnt;
    tick(2);
    chk("back_to_back_idle", 36'(idle_cnt - idle0), 36'd1);
    s = 1'b0; load = 1'b0;
    chk("back_to_back_started", {35'd0, w}, 36'd0);
    wait_idle();
    tick(1);

    // reset asserted during ADD GET_B
    in = 16'hA148; load = 1'b1; s = 1'b1;
    model_push(16'hA148);
    tick(1); load = 1'b0; s = 1'b0;
    tick(2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_getb_w", {35'd0, w}, 36'd1);
    chk("rst_getb_loadb", {35'd0, loadb}, 36'd0);
    chk("rst_getb_write", {35'd0, write}, 36'd0);
    exp_q.delete();
    @(posedge clk); #1;
    chk("rst_hold_outputs", act_vec, '0);
    rst_n = 1'b1;
    issue(16'hD0FB);

    // randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      logic [15:0] r;
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0: r[15:13] = 3'b101;
        1: r[15:13] = 3'b110;
        default: ;
      endcase
      tick($urandom_range(0, 2));
      issue(r);
    end

    tick(3);
    chk("scoreboard_drained", 36'(exp_q.size()), 36'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
